// File: rtl/os_pkg.sv
// Shared defaults and state encoding for the output-stationary max-pool reader.
package os_pkg;

    localparam int COL     = 8;
    localparam int PSUM_BW = 16;
    localparam int WIN     = 4;
    localparam int LANE_W  = PSUM_BW;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ACCUM = 2'd1;
    localparam logic [1:0] ST_HOLD  = 2'd2;

endpackage

// File: rtl/os_lane_max.sv
// One lane of the pooling reduction: signed max of the running value and a new sample.
module os_lane_max #(
    parameter int W = os_pkg::LANE_W
) (
    input  logic [W-1:0] acc,
    input  logic [W-1:0] din,
    output logic [W-1:0] max
);

    // Ties keep the accumulated value.
    always_comb begin
        if ($signed(din) > $signed(acc)) begin
            max = din;
        end else begin
            max = acc;
        end
    end

endmodule

// File: rtl/os_maxpool_reader_chk.sv
// Protocol checker for the ofifo read side of os_maxpool_reader.
module os_maxpool_reader_chk (
    input logic clk,
    input logic reset,
    input logic ofifo_rd,
    input logic ofifo_valid
);

    // A pop must never be issued against an empty ofifo.
    a_no_underflow: assert property (@(posedge clk) disable iff (!reset) ofifo_rd |-> ofifo_valid)
        else $error("ofifo underflow pop");

endmodule

// File: rtl/os_maxpool_reader.sv
// Pops ofifo rows, reduces each window of WIN rows by lane-wise signed max,
// and hands the pooled row downstream with a valid/ready handshake.
module os_maxpool_reader #(
    parameter int col     = os_pkg::COL,
    parameter int psum_bw = os_pkg::PSUM_BW,
    parameter int WIN     = os_pkg::WIN
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     max_pool_en,
    input  logic                     ofifo_valid,
    input  logic [col*psum_bw-1:0]   ofifo_out,
    output logic                     ofifo_rd,
    output logic [col*psum_bw-1:0]   pool_out,
    output logic                     pool_valid,
    input  logic                     pool_ready,
    output logic [$clog2(WIN):0]     win_cnt,
    output logic                     abort
);

    import os_pkg::*;

    localparam int CW    = $clog2(WIN) + 1;
    localparam int ROW_W = col * psum_bw;

    logic [1:0]       state_r;
    logic [CW-1:0]    win_cnt_r;
    logic [ROW_W-1:0] acc_r;
    logic [ROW_W-1:0] pool_out_r;
    logic             pool_valid_r;
    logic             abort_r;

    logic [ROW_W-1:0] max_row_s;
    logic [ROW_W-1:0] next_row_s;
    logic             pop_s;
    logic             last_s;

    for (genvar k = 0; k < col; k++) begin : g_lane
        os_lane_max #(.W(psum_bw)) u_lane_max (
            .acc (acc_r[k*psum_bw +: psum_bw]),
            .din (ofifo_out[k*psum_bw +: psum_bw]),
            .max (max_row_s[k*psum_bw +: psum_bw])
        );
    end

    // Pop decision and the row that the current pop would produce.
    always_comb begin
        pop_s  = (state_r == ST_ACCUM) && ofifo_valid && max_pool_en;
        last_s = (win_cnt_r == CW'(WIN - 1));
        if (win_cnt_r == {CW{1'b0}}) begin
            next_row_s = ofifo_out;
        end else begin
            next_row_s = max_row_s;
        end
    end

    // Window sequencing, accumulator and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r      <= ST_IDLE;
            win_cnt_r    <= {CW{1'b0}};
            acc_r        <= {ROW_W{1'b0}};
            pool_out_r   <= {ROW_W{1'b0}};
            pool_valid_r <= 1'b0;
            abort_r      <= 1'b0;
        end else begin
            abort_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (max_pool_en) begin
                        state_r <= ST_ACCUM;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_ACCUM: begin
                    if (!max_pool_en) begin
                        // Losing enable mid-window throws the partial result away.
                        state_r   <= ST_IDLE;
                        win_cnt_r <= {CW{1'b0}};
                        abort_r   <= (win_cnt_r != {CW{1'b0}});
                    end else if (pop_s) begin
                        if (last_s) begin
                            pool_out_r   <= next_row_s;
                            pool_valid_r <= 1'b1;
                            win_cnt_r    <= {CW{1'b0}};
                            state_r      <= ST_HOLD;
                        end else begin
                            acc_r     <= next_row_s;
                            win_cnt_r <= win_cnt_r + CW'(1);
                        end
                    end else begin
                        state_r <= ST_ACCUM;
                    end
                end
                ST_HOLD: begin
                    if (pool_valid_r && pool_ready) begin
                        pool_valid_r <= 1'b0;
                        state_r      <= max_pool_en ? ST_ACCUM : ST_IDLE;
                    end else begin
                        state_r <= ST_HOLD;
                    end
                end
                default: begin
                    state_r      <= ST_IDLE;
                    win_cnt_r    <= {CW{1'b0}};
                    pool_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign ofifo_rd   = pop_s;
    assign pool_out   = pool_out_r;
    assign pool_valid = pool_valid_r;
    assign win_cnt    = win_cnt_r;
    assign abort      = abort_r;

endmodule
